// File: rtl/mult_pkg.sv
// Shared operand/product types for the shift-add multiplier datapath.
package mult_pkg;

    localparam int MULT_N = 4;

    typedef logic [MULT_N-1:0]   word_t;
    typedef logic [2*MULT_N-1:0] product_t;

endpackage

// File: rtl/shift_add_datapath_rise_detect.sv
// Registered rising-edge detector; the history flop resets high so a level
// already high when reset releases is not mistaken for a new edge.
module rise_detect (
    input  logic clock,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_d;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            din_d <= 1'b1;
        end else begin
            din_d <= din;
        end
    end

    assign pulse = din & ~din_d;

endmodule

// File: rtl/shift_add_datapath.sv
// C/A/Q/M register datapath for a shift-add multiplier, with product capture.
// Optional shift counter and sticky overrun flag: define SHIFT_COUNT_EN.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clock,
    input  logic           rst,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           add,
    input  logic           shift,
    input  logic           reset,
    input  logic           ready,
    output logic           Q0,
    output logic [2*N-1:0] product,
    output logic           product_valid,
    output logic           overrun
);

    logic         c_reg;
    logic [N-1:0] acc;
    logic [N-1:0] q_reg;
    logic [N-1:0] m_reg;
    logic [N:0]   sum;
    logic         capture;

    // Full N+1-bit sum keeps the carry so the product is never truncated.
    assign sum = {1'b0, acc} + {1'b0, m_reg};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            c_reg <= 1'b0;
            acc   <= '0;
            q_reg <= '0;
            m_reg <= '0;
        end else if (reset) begin
            c_reg <= 1'b0;
            acc   <= '0;
            q_reg <= multiplier;
            m_reg <= multiplicand;
        end else begin
            unique case ({add, shift})
                2'b10: begin
                    c_reg <= sum[N];
                    acc   <= sum[N-1:0];
                end
                2'b01: begin
                    c_reg <= 1'b0;
                    acc   <= {c_reg, acc[N-1:1]};
                    q_reg <= {acc[0], q_reg[N-1:1]};
                end
                // Fused: shift the fresh sum rather than the stale {C,A}.
                2'b11: begin
                    c_reg <= 1'b0;
                    acc   <= sum[N:1];
                    q_reg <= {sum[0], q_reg[N-1:1]};
                end
                default: begin
                end
            endcase
        end
    end

    assign Q0 = q_reg[0];

    rise_detect u_ready_rise (
        .clock (clock),
        .rst   (rst),
        .din   (ready),
        .pulse (capture)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            product_valid <= capture;
            if (capture) begin
                product <= {acc, q_reg};
            end
        end
    end

`ifdef SHIFT_COUNT_EN
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    logic [CW-1:0] shift_cnt;
    logic          overrun_reg;

    // Counter saturates at N; any further shift is flagged until cleared.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            shift_cnt   <= '0;
            overrun_reg <= 1'b0;
        end else if (reset) begin
            shift_cnt   <= '0;
            overrun_reg <= 1'b0;
        end else if (shift) begin
            if (shift_cnt == CNT_MAX) begin
                overrun_reg <= 1'b1;
            end else begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    assign overrun = overrun_reg;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_datapath.sv
// Directed bench for shift_add_datapath; products checked by a queue-based monitor.
module tb_shift_add_datapath;

    logic       clock = 1'b0;
    logic       rst;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       add;
    logic       shift;
    logic       reset;
    logic       ready;
    logic       Q0;
    logic [7:0] product;
    logic       product_valid;
    logic       overrun;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    shift_add_datapath #(.N(4)) dut (
        .clock         (clock),
        .rst           (rst),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .add           (add),
        .shift         (shift),
        .reset         (reset),
        .ready         (ready),
        .Q0            (Q0),
        .product       (product),
        .product_valid (product_valid),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every product_valid pulse must match the oldest expected product.
    always @(negedge clock) begin
        if (!rst && product_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_product_valid", 32'(product_valid), 32'd0);
            end else begin
                chk("product", 32'(product), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) tick();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        // A second pulse for the same run would be caught by the monitor here.
        tick();
        tick();
    endtask

    task automatic start_mult(input logic [3:0] mc, input logic [3:0] mp);
        ready        = 1'b0;
        reset        = 1'b1;
        add          = 1'b1;
        shift        = 1'b1;
        multiplicand = mc;
        multiplier   = mp;
        tick();
        reset = 1'b0;
        add   = 1'b0;
        shift = 1'b0;
    endtask

    task automatic iterate(input bit fused, input logic expq0, input bit chk_a);
        chk("q0_sequence", 32'(Q0), 32'(expq0));
        if (chk_a) chk("acc_zero", 32'(dut.acc), 32'd0);
        if (fused) begin
            add   = Q0;
            shift = 1'b1;
            tick();
        end else begin
            if (Q0) begin
                add = 1'b1;
                tick();
                add = 1'b0;
            end
            shift = 1'b1;
            tick();
        end
        add   = 1'b0;
        shift = 1'b0;
    endtask

    task automatic finish_mult(input logic [7:0] expv, input string name);
        ready = 1'b1;
        exp_q.push_back(expv);
        tick();
        wait_drain(name);
    endtask

    initial begin
        rst          = 1'b1;
        ready        = 1'b1;
        multiplicand = 4'd13;
        multiplier   = 4'd11;
        add          = 1'b0;
        shift        = 1'b0;
        reset        = 1'b0;
        tick();
        tick();
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_valid", 32'(product_valid), 32'd0);
        chk("rst_q0", 32'(Q0), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_no_valid", 32'(product_valid), 32'd0);
        end

        // 13 x 11 = 143 with separate add and shift cycles
        start_mult(4'd13, 4'd11);
        iterate(1'b0, 1'b1, 1'b0);
        iterate(1'b0, 1'b1, 1'b0);
        iterate(1'b0, 1'b0, 1'b0);
        iterate(1'b0, 1'b1, 1'b0);
        finish_mult(8'h8F, "drain_13x11");
        chk("product_hold", 32'(product), 32'h8F);

        // 15 x 15 = 225 with fused add+shift; exercises the carry into A
        start_mult(4'd15, 4'd15);
        for (int i = 0; i < 4; i++) iterate(1'b1, 1'b1, 1'b0);
        finish_mult(8'hE1, "drain_15x15");

        // 0 x 9 = 0; Q0 walks 1,0,0,1 and A never moves
        start_mult(4'd0, 4'd9);
        iterate(1'b0, 1'b1, 1'b1);
        iterate(1'b0, 1'b0, 1'b1);
        iterate(1'b0, 1'b0, 1'b1);
        iterate(1'b0, 1'b1, 1'b1);
        chk("acc_zero_end", 32'(dut.acc), 32'd0);
        finish_mult(8'h00, "drain_0x9");

        // Asynchronous rst in the middle of 13 x 11
        start_mult(4'd13, 4'd11);
        iterate(1'b0, 1'b1, 1'b0);
        iterate(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_product", 32'(product), 32'd0);
        chk("async_rst_q0", 32'(Q0), 32'd0);
        chk("async_rst_acc", 32'(dut.acc), 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("async_rst_no_valid", 32'(product_valid), 32'd0);
        start_mult(4'd13, 4'd11);
        iterate(1'b0, 1'b1, 1'b0);
        iterate(1'b0, 1'b1, 1'b0);
        iterate(1'b0, 1'b0, 1'b0);
        iterate(1'b0, 1'b1, 1'b0);
        finish_mult(8'h8F, "drain_rerun");

        // Five shifts after a reset strobe
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("overrun_before_shift", 32'(overrun), 32'd0);
            shift = 1'b1;
            tick();
            shift = 1'b0;
        end
`ifdef SHIFT_COUNT_EN
        chk("overrun_set", 32'(overrun), 32'd1);
        tick();
        chk("overrun_sticky", 32'(overrun), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
`else
        chk("overrun_tied_low", 32'(overrun), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
